avg_sample_collector: RTL

- Upstream feeder for the divider stage: collects a stream of unsigned samples, keeps a running sum (13-bit) and a sample count (5-bit), then drives the divider's load/enable handshake.
- Output ports s/dives/lds/endiv connect directly to the divider's s/dives/lds/endiv inputs; the divider's zOz returns as div_done.
- Sequences one averaging job per start pulse and reports completion.

---
 rtl/avg_sample_collector.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/avg_sample_collector.sv
// -----------------------------------------------------------------------------
// avg_sample_collector
//
// Upstream feeder for the divider stage. Each start pulse opens one averaging
// job. The block accumulates unsigned samples into a running sum and counts
// them. It then presents sum/count to the divider and pulses lds, then endiv.
// It waits for the divider's zOz (div_done) and finally pulses done.
//
// Ports
//   clk        in   1       clock, rising edge
//   rst        in   1       asynchronous reset, active-low
//   start      in   1       begin a new job (sampled only in IDLE)
//   din        in   DATA_W  sample value
//   din_valid  in   1       din valid this cycle
//   din_last   in   1       final sample of the job (qualified by din_valid)
//   in_ready   out  1       block accepts samples (ACC only)
//   s          out  SUM_W   accumulated sum to divider
//   dives      out  CNT_W   sample count to divider
//   lds        out  1       divider load strobe
//   endiv      out  1       divider start strobe
//   div_done   in   1       divider completion (zOz)
//   busy       out  1       high in every state except IDLE
//   done       out  1       one-cycle pulse at job completion
//
// Every output comes from a flop. The strobe and status flops are loaded from
// the next-state decode, so each one is aligned with the cycle in which the
// FSM actually sits in the matching state. This keeps in_ready exact: it is
// never high in a cycle where a sample would be dropped.
//
// Legality of the parameters: MAX_CNT*(2^DATA_W-1) < 2^SUM_W and
// MAX_CNT < 2^CNT_W. Under these rules the sum and count cannot overflow, so
// the block has no saturation logic.
// -----------------------------------------------------------------------------
module avg_sample_collector #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned SUM_W   = 13,
    parameter int unsigned CNT_W   = 5,
    parameter int unsigned MAX_CNT = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    input  logic              din_last,
    output logic              in_ready,
    output logic [SUM_W-1:0]  s,
    output logic [CNT_W-1:0]  dives,
    output logic              lds,
    output logic              endiv,
    input  logic              div_done,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ACC  = 3'd1,
        ST_LOAD = 3'd2,
        ST_DIV  = 3'd3,
        ST_WAIT = 3'd4,
        ST_FIN  = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_CNT);

    state_t             state_q, state_d;
    logic [SUM_W-1:0]   s_q, s_d;
    logic [CNT_W-1:0]   dives_q, dives_d;
    logic               in_ready_q, in_ready_d;
    logic               lds_q, lds_d;
    logic               endiv_q, endiv_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [CNT_W-1:0]   cnt_inc_s;
    logic [SUM_W-1:0]   sum_inc_s;

    assign cnt_inc_s = dives_q + CNT_W'(1);
    assign sum_inc_s = s_q + SUM_W'(din);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ACC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACC: begin
                // The count test uses the incremented value. A last sample that
                // also hits MAX_CNT therefore causes only one transition.
                if (din_valid && (din_last || (cnt_inc_s == MaxCnt))) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_ACC;
                end
            end
            ST_LOAD: state_d = ST_DIV;
            ST_DIV:  state_d = ST_WAIT;
            ST_WAIT: begin
                if (div_done) begin
                    state_d = ST_FIN;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Sum/count datapath: clear on accepted start, accumulate in ACC, otherwise hold.
    always_comb begin
        s_d     = s_q;
        dives_d = dives_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    s_d     = {SUM_W{1'b0}};
                    dives_d = {CNT_W{1'b0}};
                end else begin
                    s_d     = s_q;
                    dives_d = dives_q;
                end
            end
            ST_ACC: begin
                if (din_valid) begin
                    s_d     = sum_inc_s;
                    dives_d = cnt_inc_s;
                end else begin
                    s_d     = s_q;
                    dives_d = dives_q;
                end
            end
            default: begin
                s_d     = s_q;
                dives_d = dives_q;
            end
        endcase
    end

    // Output decode from the next state, so each flop lines up with its state.
    always_comb begin
        in_ready_d = 1'b0;
        lds_d      = 1'b0;
        endiv_d    = 1'b0;
        busy_d     = 1'b1;
        done_d     = 1'b0;
        case (state_d)
            ST_IDLE: busy_d     = 1'b0;
            ST_ACC:  in_ready_d = 1'b1;
            ST_LOAD: lds_d      = 1'b1;
            ST_DIV:  endiv_d    = 1'b1;
            ST_WAIT: busy_d     = 1'b1;
            ST_FIN:  done_d     = 1'b1;
            default: busy_d     = 1'b0;
        endcase
    end

    // Datapath and output registers; reset clears everything at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_q        <= {SUM_W{1'b0}};
            dives_q    <= {CNT_W{1'b0}};
            in_ready_q <= 1'b0;
            lds_q      <= 1'b0;
            endiv_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            s_q        <= s_d;
            dives_q    <= dives_d;
            in_ready_q <= in_ready_d;
            lds_q      <= lds_d;
            endiv_q    <= endiv_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign in_ready = in_ready_q;
    assign s        = s_q;
    assign dives    = dives_q;
    assign lds      = lds_q;
    assign endiv    = endiv_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
